// File: rtl/serial_adder_ctrl_pkg.sv
// Shared state encoding for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell; purely combinational, streamed by serial_adder_ctrl.
module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: streams operands LSB-first through one FullAdder, one bit per clock.
// Define SERIAL_ADD_OVERFLOW_EN to add the signed-overflow output V.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADD_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, res;
    logic             carry;
    logic [CNT_W-1:0] count;
    logic             fa_sum, fa_cout;
    logic             last;

    FullAdder u_fa (
        .A    (op_a[0]),
        .B    (op_b[0]),
        .Cin  (carry),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    assign last = (count == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            count <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
            V     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (start) begin
                    op_a  <= A;
                    op_b  <= B;
                    carry <= Cin;
                    count <= '0;
                end
                SHIFT: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_cout;
                    res   <= {fa_sum, res[WIDTH-1:1]};
                    count <= count + 1'b1;
                    // On the last bit, carry holds the carry into the MSB
                    if (last) begin
                        Sum  <= {fa_sum, res[WIDTH-1:1]};
                        Cout <= fa_cout;
`ifdef SERIAL_ADD_OVERFLOW_EN
                        V    <= carry ^ fa_cout;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: cycle-level arithmetic model of serial_adder_ctrl plus literal pins.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start, Cin;
    logic [W-1:0] A, B;
    logic         busy, done, Cout;
    logic [W-1:0] Sum;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic         V;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout)
`ifdef SERIAL_ADD_OVERFLOW_EN
        ,
        .V     (V)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit fin   = 1'b0;

    // Literal expectations for the first four accepted adds: {Cout,Sum} and V
    logic [W:0] pin_res [4] = '{9'h07F, 9'h100, 9'h080, 9'h100};
    logic       pin_v   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Model + compare: an accepted add at edge c is busy after edges c..c+W-1,
    // done after edge c+W, and the next start can be taken from edge c+W+2.
    initial begin
        int         e = 0, c = 0, idx = 0;
        int         n_acc = 0, n_done = 0, n_done_exp = 0;
        bit         have = 1'b0;
        logic [W:0] pend = '0, exp_res = '0;
        logic       pend_v = 1'b0, exp_v = 1'b0;
        bit         exp_busy, exp_done;
        forever begin
            @(posedge clk);
            e++;
            if (reset) begin
                have    = 1'b0;
                exp_res = '0;
                exp_v   = 1'b0;
            end else begin
                if (have && e == c + W) begin
                    exp_res = pend;
                    exp_v   = pend_v;
                    n_done_exp++;
                end
                if (start && (!have || e >= c + W + 2)) begin
                    have   = 1'b1;
                    c      = e;
                    idx    = n_acc;
                    pend   = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
                    pend_v = (A[W-1] == B[W-1]) && (pend[W-1] != A[W-1]);
                    n_acc++;
                end
            end
            exp_busy = have && e >= c && e <= c + W - 1;
            exp_done = have && e == c + W;
            #1;
            if (fin) begin
                chk("done_count", e, n_done, n_done_exp);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            chk("busy", e, busy, exp_busy);
            chk("done", e, done, exp_done);
            chk("result", e, {Cout, Sum}, exp_res);
`ifdef SERIAL_ADD_OVERFLOW_EN
            chk("V", e, V, exp_v);
`endif
            if (done) n_done++;
            if (exp_done && idx < 4) begin
                chk("pin_result", e, {Cout, Sum}, pin_res[idx]);
`ifdef SERIAL_ADD_OVERFLOW_EN
                chk("pin_V", e, V, pin_v[idx]);
`endif
            end
        end
    end

    task automatic add_once(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        @(negedge clk);
        start = 1'b1; A = a; B = b; Cin = ci;
        @(negedge clk);
        start = 1'b0; A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        repeat (W + 1) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        add_once(8'h35, 8'h4A, 1'b0);
        add_once(8'hFF, 8'h01, 1'b0);
        add_once(8'h7F, 8'h01, 1'b0);
        add_once(8'hFF, 8'h00, 1'b1);

        // start held high with operands changing every cycle
        @(negedge clk);
        start = 1'b1;
        repeat (3 * (W + 2) + 2) begin
            A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // reset during the fourth SHIFT cycle aborts the add
        start = 1'b1; A = 8'hAA; B = 8'h55; Cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 3) @(negedge clk);

        // random adds with spurious starts while busy/done
        repeat (1000) begin
            int gap;
            A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
            start = 1'b1;
            @(negedge clk);
            gap = $urandom_range(W + 1, W + 4);
            for (int i = 0; i < gap; i++) begin
                start = (i <= W) ? 1'($urandom) : 1'b0;
                A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
                @(negedge clk);
            end
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);
        fin = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
